// File: rtl/seq_det_fsm.sv
// Parametrised serial pattern detector: pulses dout one cycle after PAT is seen, MSB first.
// Optional macro SEQ_DET_TIMEOUT_EN discards a stale partial match after TIMEOUT idle cycles.
module seq_det_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT     = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             ovl_en,
    input  logic             clr,
    output logic             dout,
    output logic [PAT_W:0]   state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int LEN_W = $clog2(PAT_W);
    localparam int TBL_W = (2 ** (LEN_W + 1)) * LEN_W;

    if (PAT_W < 2 || PAT_W > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("seq_det_fsm: PAT_W must be 2..16 and TIMEOUT >= 1");
    end

    // Entry {k, b}: longest proper prefix of PAT that is a suffix of (first k bits of PAT, b).
    // For a hit below full length this is k+1; for a full match it is the overlap border.
    function automatic logic [TBL_W-1:0] build_tbl();
        logic [TBL_W-1:0] t;
        int               best;
        int               p;
        logic             ok;
        logic             sb;
        t = '0;
        for (int k = 0; k < PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= k + 1; j++) begin
                    if (j < PAT_W) begin
                        ok = 1'b1;
                        for (int i = 0; i < j; i++) begin
                            p  = k + 1 - j + i;
                            sb = (p == k) ? b[0] : PAT[PAT_W-1-p];
                            if (sb != PAT[PAT_W-1-i]) ok = 1'b0;
                        end
                        if (ok) best = j;
                    end
                end
                t[(k*2+b)*LEN_W +: LEN_W] = best[LEN_W-1:0];
            end
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               exp_bit;
    logic               full_hit;
    logic [LEN_W-1:0]   tbl_val;
    int                 tbl_idx;
`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        phase_d     = phase_q;
        len_d       = len_q;
        dout_d      = 1'b0;
        match_cnt_d = match_cnt_q;
        exp_bit     = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (len_q == LEN_W'(i)) exp_bit = PAT[PAT_W-1-i];
        end
        full_hit = (din == exp_bit) && (len_q == LEN_W'(PAT_W - 1));
        tbl_idx  = int'({len_q, din});
        tbl_val  = NEXT_TBL[tbl_idx*LEN_W +: LEN_W];
`ifdef SEQ_DET_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (clr) begin
            phase_d     = PH_IDLE;
            len_d       = '0;
            match_cnt_d = '0;
        end else if (din_vld) begin
            phase_d = PH_RUN;
            if (full_hit) begin
                len_d  = ovl_en ? tbl_val : '0;
                dout_d = 1'b1;
                if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
            end else begin
                len_d = tbl_val;
            end
        end
`ifdef SEQ_DET_TIMEOUT_EN
        // Only partial matches (k > 0) age out; M0 and IDLE ignore gaps.
        else if (phase_q == PH_RUN && len_q != '0) begin
            if (idle_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                len_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q     <= PH_IDLE;
            len_q       <= '0;
            dout_q      <= 1'b0;
            match_cnt_q <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            phase_q     <= phase_d;
            len_q       <= len_d;
            dout_q      <= dout_d;
            match_cnt_q <= match_cnt_d;
`ifdef SEQ_DET_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    always_comb begin
        state    = '0;
        state[0] = (phase_q == PH_IDLE);
        for (int i = 0; i < PAT_W; i++) begin
            state[i+1] = (phase_q == PH_RUN) && (len_q == LEN_W'(i));
        end
    end

    assign dout      = dout_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// Randomised and directed bench for seq_det_fsm against a history-based reference model.
// Build with SEQ_DET_TIMEOUT_EN defined to exercise the idle timeout as well.
module tb_seq_det_fsm;
    localparam int               PAT_W = 4;
    localparam logic [PAT_W-1:0] PAT   = 4'b1011;
    localparam int               CNT_W = 2;
`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic             clk = 1'b0;
    logic             rst, din, din_vld, ovl_en, clr;
    logic             dout;
    logic [PAT_W:0]   state;
    logic [CNT_W-1:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the consumed bits since the last restart, newest in bit 0.
    bit          m_idle;
    logic [31:0] hist;
    int          hlen;
    bit          m_dout;
    int          m_cnt;
    int          m_tmo;

    seq_det_fsm #(.PAT_W(PAT_W), .PAT(PAT), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .ovl_en(ovl_en), .clr(clr),
        .dout(dout), .state(state), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Longest proper prefix of PAT that the history currently ends with.
    function automatic int model_k();
        int best;
        best = 0;
        for (int j = 1; j < PAT_W; j++) begin
            if (j <= hlen) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < j; i++) if (hist[j-1-i] !== PAT[PAT_W-1-i]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_step(input logic b, input logic v, input logic o, input logic c, input logic r);
        if (!r || c) begin
            m_idle = 1'b1; hist = '0; hlen = 0; m_dout = 1'b0; m_cnt = 0; m_tmo = 0;
        end else if (v) begin
            m_idle = 1'b0;
            m_tmo  = 0;
            hist   = {hist[30:0], b};
            if (hlen < 32) hlen++;
            if (hlen >= PAT_W && hist[PAT_W-1:0] == PAT) begin
                m_dout = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!o) hlen = 0;
            end else begin
                m_dout = 1'b0;
            end
        end else begin
            m_dout = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            if (!m_idle && model_k() > 0) begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    hlen  = 0;
                    m_tmo = 0;
                end
            end else begin
                m_tmo = 0;
            end
`endif
        end
    endtask

    task automatic cyc(input logic b, input logic v, input logic o, input logic c, input logic r);
        logic [31:0] exp_state;
        din = b; din_vld = v; ovl_en = o; clr = c; rst = r;
        @(posedge clk);
        model_step(b, v, o, c, r);
        #1;
        exp_state = m_idle ? 32'd1 : (32'd1 << (model_k() + 1));
        check("state", 32'(state), exp_state);
        check("onehot", 32'($onehot(state)), 32'd1);
        check("dout", 32'(dout), 32'(m_dout));
        check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic send(input logic [15:0] bits, input int n, input logic o);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, o, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] s4;
        int         ek[8];
        int         sat[5];
        rst = 1'b0; din = 1'b0; din_vld = 1'b0; ovl_en = 1'b0; clr = 1'b0;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rst_state", 32'(state), 32'd1);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        repeat (5) cyc(0, 0, 0, 0, 1);
        check("idle_hold", 32'(state), 32'd1);

        send(16'b1011011, 7, 1'b1);
        check("ovl_cnt", 32'(match_cnt), 32'd2);

        cyc(0, 0, 0, 1, 1);
        send(16'b1011011, 7, 1'b0);
        check("novl_cnt", 32'(match_cnt), 32'd1);

        cyc(0, 0, 0, 1, 1);
        s4 = 8'b10101011;
        ek = '{1, 2, 3, 2, 3, 2, 3, 0};
        for (int i = 0; i < 8; i++) begin
            cyc(s4[7-i], 1'b1, 1'b0, 1'b0, 1'b1);
            check("walk_state", 32'(state), 32'd1 << (ek[i] + 1));
        end
        check("walk_dout", 32'(dout), 32'd1);

        cyc(0, 0, 0, 1, 1);
        send(16'b101, 3, 1'b1);
        cyc(0, 0, 1, 0, 0);
        send(16'b011, 3, 1'b1);
        check("rst_mid_cnt", 32'(match_cnt), 32'd0);
        send(16'b1011, 4, 1'b1);
        check("after_rst_match", 32'(dout), 32'd1);

        cyc(0, 0, 0, 1, 1);
        sat = '{1, 2, 3, 3, 3};
        for (int m = 0; m < 5; m++) begin
            send(16'b1011, 4, 1'b1);
            check("sat_cnt", 32'(match_cnt), 32'(sat[m]));
        end
        send(16'b101, 3, 1'b1);
        cyc(1, 1, 1, 1, 1);
        check("clr_dout", 32'(dout), 32'd0);
        check("clr_cnt", 32'(match_cnt), 32'd0);
        check("clr_state", 32'(state), 32'd1);

`ifdef SEQ_DET_TIMEOUT_EN
        send(16'b101, 3, 1'b1);
        repeat (TMO) cyc(0, 0, 1, 0, 1);
        check("tmo_m0", 32'(state), 32'd2);
        cyc(1, 1, 1, 0, 1);
        check("tmo_m1", 32'(state), 32'd4);
        cyc(1, 1, 1, 0, 1);
        check("tmo_stale", 32'(dout), 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            cyc(1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                (r == 0), (r != 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
